// File: rtl/wishbone_master_engine.sv
`default_nettype none
// ============================================================================
// Module      : wishbone_master_engine
// Description : Wishbone classic-cycle initiator. Each command accepted on the
//               cmd_* valid/ready handshake becomes exactly one Wishbone
//               transaction. Its result is returned on the rsp_* valid/ready
//               handshake. Only one transaction is outstanding at a time.
//               Slave select is wbm_adr_o[31:24].
// Optional    : WB_MASTER_TIMEOUT_EN - when defined, the engine aborts a bus
//               cycle that sees no ack within TIMEOUT cycles and returns
//               rsp_err=1. When undefined, it waits for ack indefinitely and
//               rsp_err is tied to 0.
// Ports       : clk, rst                  - clock, synchronous active-high reset
//               cmd_valid/ready/we/adr/dat/sel - command channel
//               rsp_valid/ready/dat/err   - response channel
//               wbm_*_o / wbm_*_i         - Wishbone master port
//               wbm_int_i -> irq_o        - interrupt summary, registered once
// Revision    : 1.0 - initial release
// ============================================================================
module wishbone_master_engine #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_int_i,
    output logic        irq_o
);

    // TIMEOUT must fit the 16-bit cycle counter and allow at least one wait cycle.
    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("wishbone_master_engine: TIMEOUT out of range 2..65535");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic        irq_q;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam logic [15:0] C_TO_LAST = 16'(TIMEOUT - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        rsp_err_q, rsp_err_d;
    logic        w_timeout_hit;

    assign w_timeout_hit = (cnt_q == C_TO_LAST);
    assign rsp_err       = rsp_err_q;
`else
    assign rsp_err       = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
`ifdef WB_MASTER_TIMEOUT_EN
        cnt_d       = cnt_q;
        rsp_err_d   = rsp_err_q;
`endif

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    we_d  = cmd_we;
                    adr_d = cmd_adr;
                    // Keep the write-data bus quiet on reads.
                    dat_d = cmd_we ? cmd_dat : 32'h0;
                    sel_d = cmd_sel;
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
`ifdef WB_MASTER_TIMEOUT_EN
                    cnt_d = 16'h0;
`endif
                    state_d = BUS;
                end
            end

            BUS: begin
                // An ack on the same edge as the timeout takes priority.
                if (wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    we_d        = 1'b0;
                    sel_d       = 4'h0;
                    adr_d       = 32'h0;
                    dat_d       = 32'h0;
                    rsp_dat_d   = we_q ? 32'h0 : wbm_dat_i;
                    rsp_valid_d = 1'b1;
`ifdef WB_MASTER_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                    state_d     = RESP;
                end
`ifdef WB_MASTER_TIMEOUT_EN
                else if (w_timeout_hit) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    we_d        = 1'b0;
                    sel_d       = 4'h0;
                    adr_d       = 32'h0;
                    dat_d       = 32'h0;
                    rsp_dat_d   = 32'h0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
                else if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end

            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'h0;
            adr_q       <= 32'h0;
            dat_q       <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= 32'h0;
            irq_q       <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
            cnt_q       <= 16'h0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            irq_q       <= wbm_int_i;
`ifdef WB_MASTER_TIMEOUT_EN
            cnt_q       <= cnt_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    // cmd_ready is the only combinational output; it is forced low during reset.
    assign cmd_ready = (state_q == IDLE) && !rst;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign wbm_we_o  = we_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = stb_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign irq_o     = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_wishbone_master_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_wishbone_master_engine
// Description : Directed self-checking bench for wishbone_master_engine.
//               Inputs are driven and outputs sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wishbone_master_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = 32'h0;
    logic [31:0] cmd_dat = 32'h0;
    logic [3:0]  cmd_sel = 4'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wbm_we_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i = 32'h0;
    logic        wbm_ack_i = 1'b0;
    logic        wbm_int_i = 1'b0;
    logic        irq_o;

    int n_vec = 0;
    int n_err = 0;

    wishbone_master_engine #(.TIMEOUT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .wbm_we_o  (wbm_we_o),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i),
        .wbm_int_i (wbm_int_i),
        .irq_o     (irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Presents a command for one edge; returns in cycle N+1 (strobe cycle).
    task automatic issue(input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
        check("issue_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        step();
        cmd_valid = 1'b0;
        cmd_dat   = 32'h0;
        check("issue_cyc", {31'h0, wbm_cyc_o}, 32'h1);
        check("issue_stb", {31'h0, wbm_stb_o}, 32'h1);
        check("issue_adr", wbm_adr_o, adr);
        check("issue_we",  {31'h0, wbm_we_o}, {31'h0, we});
        check("issue_sel", {28'h0, wbm_sel_o}, {28'h0, sel});
        check("issue_dat", wbm_dat_o, we ? dat : 32'h0);
        check("issue_busy", {31'h0, cmd_ready}, 32'h0);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("hs_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("hs_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    endtask

    initial begin
        // ---------------- reset state ----------------
        step();
        step();
        check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        check("rst_cyc", {31'h0, wbm_cyc_o}, 32'h0);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_adr", wbm_adr_o, 32'h0);
        check("rst_irq", {31'h0, irq_o}, 32'h0);
        rst = 1'b0;
        step();
        check("idle_cmd_ready", {31'h0, cmd_ready}, 32'h1);

        // ---------------- write, ack 3 cycles after strobe ----------------
        wbm_dat_i = 32'hFFFF_FFFF;
        issue(1'b1, 32'h0100_0010, 32'hDEAD_BEEF, 4'hF);
        for (int i = 0; i < 3; i++) begin
            step();
            check("wr_hold_adr", wbm_adr_o, 32'h0100_0010);
            check("wr_hold_dat", wbm_dat_o, 32'hDEAD_BEEF);
            check("wr_hold_stb", {31'h0, wbm_stb_o}, 32'h1);
            check("wr_no_rsp", {31'h0, rsp_valid}, 32'h0);
        end
        wbm_ack_i = 1'b1;
        step();
        wbm_ack_i = 1'b0;
        check("wr_cyc_clr", {31'h0, wbm_cyc_o}, 32'h0);
        check("wr_stb_clr", {31'h0, wbm_stb_o}, 32'h0);
        check("wr_adr_clr", wbm_adr_o, 32'h0);
        check("wr_dat_clr", wbm_dat_o, 32'h0);
        check("wr_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        check("wr_rsp_dat", rsp_dat, 32'h0);
        check("wr_rsp_err", {31'h0, rsp_err}, 32'h0);
        handshake();

        // ---------------- read, ack in first strobe cycle ----------------
        issue(1'b0, 32'h0000_0004, 32'h5555_AAAA, 4'hF);
        check("rd_no_rsp_n1", {31'h0, rsp_valid}, 32'h0);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h1234_5678;
        step();
        wbm_ack_i = 1'b0;
        check("rd_rsp_valid_n2", {31'h0, rsp_valid}, 32'h1);
        check("rd_rsp_dat", rsp_dat, 32'h1234_5678);
        check("rd_dat_o", wbm_dat_o, 32'h0);
        check("rd_cyc_clr", {31'h0, wbm_cyc_o}, 32'h0);
        handshake();

        // ---------------- backpressure ----------------
        issue(1'b0, 32'h0200_0008, 32'h0, 4'h3);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'hCAFE_F00D;
        step();
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0BAD_0BAD;
        for (int i = 0; i < 5; i++) begin
            // Pulse a command and a stray ack while the response is held.
            cmd_valid = (i == 1);
            cmd_we    = 1'b1;
            cmd_adr   = 32'h0300_0000;
            wbm_ack_i = (i == 2);
            check("bp_cmd_ready", {31'h0, cmd_ready}, 32'h0);
            check("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
            check("bp_rsp_dat", rsp_dat, 32'hCAFE_F00D);
            check("bp_cyc", {31'h0, wbm_cyc_o}, 32'h0);
            step();
        end
        cmd_valid = 1'b0;
        wbm_ack_i = 1'b0;
        check("bp_cyc_end", {31'h0, wbm_cyc_o}, 32'h0);
        check("bp_rsp_dat_end", rsp_dat, 32'hCAFE_F00D);
        handshake();
        issue(1'b1, 32'h0300_0000, 32'h0000_00FF, 4'h1);
        wbm_ack_i = 1'b1;
        step();
        wbm_ack_i = 1'b0;
        check("bp2_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        check("bp2_rsp_dat", rsp_dat, 32'h0);
        handshake();

`ifdef WB_MASTER_TIMEOUT_EN
        // ---------------- timeout, TIMEOUT=8 ----------------
        begin
            int cyc_cnt = 0;
            issue(1'b0, 32'h0400_0000, 32'h0, 4'hF);
            for (int i = 0; i < 20 && wbm_cyc_o; i++) begin
                cyc_cnt++;
                step();
            end
            check("to_cyc_cycles", 32'(cyc_cnt), 32'd8);
            check("to_rsp_valid", {31'h0, rsp_valid}, 32'h1);
            check("to_rsp_err", {31'h0, rsp_err}, 32'h1);
            check("to_rsp_dat", rsp_dat, 32'h0);
            handshake();
        end
        issue(1'b0, 32'h0400_0004, 32'h0, 4'hF);
        for (int i = 0; i < 7; i++) step();
        check("to2_cyc_c8", {31'h0, wbm_cyc_o}, 32'h1);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h8888_7777;
        step();
        wbm_ack_i = 1'b0;
        check("to2_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        check("to2_rsp_err", {31'h0, rsp_err}, 32'h0);
        check("to2_rsp_dat", rsp_dat, 32'h8888_7777);
        handshake();
`endif

        // ---------------- reset mid-BUS ----------------
        wbm_int_i = 1'b1;
        issue(1'b0, 32'h0500_0000, 32'h0, 4'hF);
        check("irq_set", {31'h0, irq_o}, 32'h1);
        rst = 1'b1;
        step();
        check("mr_cyc", {31'h0, wbm_cyc_o}, 32'h0);
        check("mr_stb", {31'h0, wbm_stb_o}, 32'h0);
        check("mr_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("mr_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        check("mr_irq", {31'h0, irq_o}, 32'h0);
        rst = 1'b0;
        wbm_int_i = 1'b0;
        step();
        check("mr_cmd_ready_after", {31'h0, cmd_ready}, 32'h1);
        check("mr_no_rsp", {31'h0, rsp_valid}, 32'h0);
        issue(1'b0, 32'h0600_0000, 32'h0, 4'hF);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'hA5A5_5A5A;
        wbm_int_i = 1'b1;
        step();
        wbm_ack_i = 1'b0;
        check("mr_rd_rsp_dat", rsp_dat, 32'hA5A5_5A5A);
        check("irq_in_resp", {31'h0, irq_o}, 32'h1);
        wbm_int_i = 1'b0;
        step();
        check("irq_clr", {31'h0, irq_o}, 32'h0);
        check("resp_held", {31'h0, rsp_valid}, 32'h1);
        handshake();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wishbone_master_engine.md
Name: wishbone_master_engine

Overview:
- Wishbone initiator that turns single-word commands into one classic-cycle Wishbone transaction each. It drives the master port of the bus interconnect.
- Accepts commands on a valid/ready handshake and returns a response on a valid/ready handshake.
- Serves host-interface logic (UART/USB command parsers) that needs blocking single reads and writes into the slave address map; slave select is adr[31:24].

Parameters:
- TIMEOUT, 1024, bus cycles to wait for ack before aborting (only with WB_MASTER_TIMEOUT_EN); legal range 2..65535.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command
- cmd_we  in  1  1=write, 0=read
- cmd_adr  in  32  byte address; [31:24] selects the slave
- cmd_dat  in  32  write data
- cmd_sel  in  4  byte lane select
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_dat  out  32  read data (0 for writes and errors)
- rsp_err  out  1  transaction aborted by timeout
- wbm_we_o  out  1  Wishbone write enable
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_sel_o  out  4  Wishbone byte select
- wbm_adr_o  out  32  Wishbone address
- wbm_dat_o  out  32  Wishbone write data
- wbm_dat_i  in  32  Wishbone read data
- wbm_ack_i  in  1  Wishbone acknowledge
- wbm_int_i  in  1  interconnect interrupt summary
- irq_o  out  1  wbm_int_i registered once

Behaviour:
- One clock domain; reset is synchronous, active-high, on clk.
- All outputs are registered except cmd_ready, which is (state==IDLE) && !rst.
- Reset values: all outputs 0, state IDLE. Wishbone bus outputs and irq_o are 0 while rst is high.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready=1.
  - On edge with cmd_valid: latch we/adr/dat/sel onto wbm_*_o, set cyc=stb=1, clear cycle counter, go to BUS.
  - wbm_dat_o is loaded only when cmd_we=1; otherwise it is 0.
- BUS:
  - cyc/stb/adr/sel/we/dat held stable.
  - On edge with wbm_ack_i: clear cyc, stb, we, sel, adr and dat to 0.
  - Load rsp_dat with wbm_dat_i for reads, or 0 for writes. Set rsp_err=0 and rsp_valid=1, then go to RESP.
  - Otherwise the counter increments; it saturates and does not wrap.
- RESP:
  - rsp_valid=1, with rsp_dat/rsp_err held.
  - On edge with rsp_ready: rsp_valid=0, go to IDLE.
- Latency, with ack returned in the first strobe cycle:
  - Command accepted at edge N.
  - stb high during cycle N+1; ack sampled at edge N+2.
  - rsp_valid high from N+2.
  - cmd_ready high again the cycle after the rsp_ready handshake.
- Back-to-back: at most one outstanding transaction. The next command is accepted no earlier than the cycle after the response handshake.
- wbm_ack_i in IDLE or RESP is ignored and does not alter any output.
- cmd_valid while not IDLE is ignored. The command is not consumed (cmd_ready=0).
- Reset mid-BUS or mid-RESP: the transaction is dropped with no response. cyc/stb are 0 from the first edge with rst high.
- irq_o <= wbm_int_i every edge; reset clears it.

Optional Feature:
- Macro: WB_MASTER_TIMEOUT_EN.
- Defined:
  - In BUS, if no ack has arrived and the counter equals TIMEOUT-1 at an edge, the engine aborts at that edge.
  - Abort clears cyc/stb, sets rsp_dat=0, rsp_err=1, rsp_valid=1, and moves to RESP.
  - An ack at the same edge wins: normal response, rsp_err=0.
- Undefined:
  - The engine waits in BUS indefinitely; rsp_err is tied to 0.
  - The counter logic is absent.

Test Plan:
- Write: cmd we=1 adr=0x0100_0010 dat=0xDEADBEEF sel=0xF, slave acks 3 cycles after stb -> wbm_adr_o=0x0100_0010, wbm_dat_o=0xDEADBEEF held until ack; then rsp_valid=1, rsp_dat=0, rsp_err=0.
- Read: cmd we=0 adr=0x0000_0004, slave acks on first stb cycle with 0x1234_5678 -> rsp_valid at accept+2, rsp_dat=0x1234_5678; wbm_dat_o=0 throughout.
- Backpressure: hold rsp_ready=0 for 5 cycles, with cmd_valid pulsed in between -> cmd_ready=0 throughout, rsp held stable, no second cyc; after rsp_ready the second command issues.
- Timeout (macro on, TIMEOUT=8): read with no ack -> cyc high exactly 8 cycles, then rsp_err=1, rsp_dat=0. Repeat with ack on the 8th cycle -> rsp_err=0, data returned.
- Reset mid-BUS: assert rst while stb=1 -> cyc/stb=0 next edge, no rsp_valid; after rst release cmd_ready=1 and a new read completes normally.
- Interrupt: toggle wbm_int_i 0->1 -> irq_o=1 one edge later, independent of FSM state.
